// File: rtl/hog_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hog_pkg
//  Description : Shared constants and stage FSM encoding for the HOG
//                dataflow sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package hog_pkg;

    localparam int HOG_NUM_STAGES = 4;

    localparam int STG_ACQUIRE   = 0;
    localparam int STG_GRADIENTS = 1;
    localparam int STG_CELLS     = 2;
    localparam int STG_SVM       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } stage_state_e;

endpackage : hog_pkg
`default_nettype wire

// File: rtl/hog_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hog_stage_ctrl
//  Description : One pipeline stage: pending-frame counter plus the
//                IDLE/START/BUSY ap_start handshake FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module hog_stage_ctrl
    import hog_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic ready,
    input  logic done,
    output logic start,
    output logic active
);

    stage_state_e state_q, state_d;
    logic [1:0]   pend_q, pend_d;
    logic         w_handshake;

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        w_handshake = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q != 2'd0) state_d = ST_START;
            end
            ST_START: begin
                start = 1'b1;
                if (ready) begin
                    w_handshake = 1'b1;
                    state_d     = done ? ST_IDLE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Arrival and handshake in the same cycle cancel out.
        pend_d = pend_q;
        if (inc && !w_handshake && (pend_q != 2'd3))
            pend_d = pend_q + 2'd1;
        else if (!inc && w_handshake)
            pend_d = pend_q - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign active = (state_q == ST_START) || (state_q == ST_BUSY);

endmodule : hog_stage_ctrl
`default_nettype wire

// File: rtl/hog_pipe_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hog_pipe_sequencer
//  Description : Frame admission, per-stage start sequencing, in-flight
//                accounting and stall watchdog for the HOG pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module hog_pipe_sequencer
    import hog_pkg::*;
#(
    parameter int NUM_STAGES   = HOG_NUM_STAGES,
    parameter int MAX_INFLIGHT = 2,
    parameter int WD_TIMEOUT   = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_req,
    output logic                  frame_ack,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_ready,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic                  frame_done,
    output logic [1:0]            inflight,
    output logic                  stall,
    output logic [1:0]            stall_stage,
    input  logic                  stall_clear
);

    localparam logic [15:0] C_WD_LIMIT = 16'(WD_TIMEOUT);
    localparam logic [1:0]  C_MAX_INFL = 2'(MAX_INFLIGHT);

    logic [1:0]            inflight_q, inflight_d;
    logic [15:0]           wd_q, wd_d;
    logic                  stall_q, stall_d;
    logic [1:0]            stall_stage_q, stall_stage_d;
    logic                  frame_done_q, frame_done_d;

    logic                  w_accept;
    logic                  w_retire;
    logic [NUM_STAGES-1:0] w_active;
    logic [1:0]            w_first_active;

    assign w_accept = frame_req && (inflight_q < C_MAX_INFL) && !stall_q;
    assign w_retire = stage_done[NUM_STAGES-1] && (inflight_q != 2'd0);

    // Stage 0 is fed by admissions, every later stage by its predecessor.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        logic w_inc;
        if (gi == 0) begin : g_first
            assign w_inc = w_accept;
        end else begin : g_chain
            assign w_inc = stage_done[gi-1];
        end

        hog_stage_ctrl u_ctrl (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc    (w_inc),
            .ready  (stage_ready[gi]),
            .done   (stage_done[gi]),
            .start  (stage_start[gi]),
            .active (w_active[gi])
        );
    end

    always_comb begin
        w_first_active = 2'd0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (w_active[i]) w_first_active = 2'(i);
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (w_accept && !w_retire)
            inflight_d = inflight_q + 2'd1;
        else if (!w_accept && w_retire)
            inflight_d = inflight_q - 2'd1;

        wd_d = wd_q;
        if ((|stage_done) || (inflight_q == 2'd0) || stall_clear)
            wd_d = 16'd0;
        else if (wd_q != C_WD_LIMIT)
            wd_d = wd_q + 16'd1;

        // Stall is sticky; clear wins over a same-cycle set.
        stall_d       = stall_q;
        stall_stage_d = stall_stage_q;
        if (stall_clear) begin
            stall_d = 1'b0;
        end else if (!stall_q && (wd_d == C_WD_LIMIT)) begin
            stall_d       = 1'b1;
            stall_stage_d = w_first_active;
        end

        frame_done_d = stage_done[NUM_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q    <= 2'd0;
            wd_q          <= 16'd0;
            stall_q       <= 1'b0;
            stall_stage_q <= 2'd0;
            frame_done_q  <= 1'b0;
        end else begin
            inflight_q    <= inflight_d;
            wd_q          <= wd_d;
            stall_q       <= stall_d;
            stall_stage_q <= stall_stage_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign frame_ack   = w_accept;
    assign inflight    = inflight_q;
    assign stall       = stall_q;
    assign stall_stage = stall_stage_q;
    assign frame_done  = frame_done_q;

endmodule : hog_pipe_sequencer
`default_nettype wire

// File: tb/tb_hog_pipe_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hog_pipe_sequencer
//  Description : Self-checking bench with a cycle-level behavioural model
//                and bench-driven stage responders.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hog_pipe_sequencer;

    localparam int N    = 4;
    localparam int MAXI = 2;
    localparam int WD   = 100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_req = 1'b0;
    logic         stall_clear = 1'b0;
    logic [N-1:0] stage_ready = '0;
    logic [N-1:0] stage_done = '0;
    logic [N-1:0] stage_start;
    logic         frame_ack, frame_done, stall;
    logic [1:0]   inflight, stall_stage;

    always #5 clk = ~clk;

    hog_pipe_sequencer #(
        .NUM_STAGES  (N),
        .MAX_INFLIGHT(MAXI),
        .WD_TIMEOUT  (WD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_req   (frame_req),
        .frame_ack   (frame_ack),
        .stage_start (stage_start),
        .stage_ready (stage_ready),
        .stage_done  (stage_done),
        .frame_done  (frame_done),
        .inflight    (inflight),
        .stall       (stall),
        .stall_stage (stall_stage),
        .stall_clear (stall_clear)
    );

    int errors = 0;
    int checks = 0;

    // Model: phase 0 = waiting, 1 = requesting start, 2 = working.
    int m_pend [N];
    int m_ph   [N];
    int age    [N];
    int rdly   [N];
    int ddly   [N];
    int m_infl, m_wd, m_stall, m_stall_stage, m_fdone;
    bit rnd_mode = 1'b0;
    bit chk_en   = 1'b0;
    bit req_next = 1'b0;
    bit clr_next = 1'b0;
    int n_ack, n_fdone;
    int n_start_cyc [N];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_ph[i] = 0; age[i] = 0;
        end
        m_infl = 0; m_wd = 0; m_stall = 0; m_stall_stage = 0; m_fdone = 0;
    endtask

    task automatic clear_counts();
        n_ack = 0; n_fdone = 0;
        for (int i = 0; i < N; i++) n_start_cyc[i] = 0;
    endtask

    // Advance the model by one clock using the inputs present at that edge.
    task automatic model_step();
        int acc, first, wd_n, retire;
        int old_ph [N];
        int hs     [N];
        acc = (frame_req && m_infl < MAXI && m_stall == 0) ? 1 : 0;
        first = 0;
        for (int i = N - 1; i >= 0; i--) if (m_ph[i] != 0) first = i;
        for (int i = 0; i < N; i++) begin
            old_ph[i] = m_ph[i];
            hs[i] = (m_ph[i] == 1 && stage_ready[i]) ? 1 : 0;
            if (m_ph[i] == 0 && m_pend[i] > 0) m_ph[i] = 1;
            else if (m_ph[i] == 1 && stage_ready[i]) m_ph[i] = stage_done[i] ? 0 : 2;
            else if (m_ph[i] == 2 && stage_done[i]) m_ph[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] += ((i == 0) ? acc : int'(stage_done[i-1])) - hs[i];
            age[i] = (m_ph[i] != old_ph[i]) ? 0 : age[i] + 1;
        end
        if (stage_done != '0 || m_infl == 0 || stall_clear) wd_n = 0;
        else wd_n = (m_wd + 1 > WD) ? WD : m_wd + 1;
        if (stall_clear) m_stall = 0;
        else if (m_stall == 0 && wd_n == WD) begin
            m_stall = 1; m_stall_stage = first;
        end
        m_wd = wd_n;
        retire = (stage_done[N-1] && m_infl > 0) ? 1 : 0;
        m_infl = m_infl + acc - retire;
        m_fdone = stage_done[N-1];
    endtask

    task automatic step();
        logic [N-1:0] rdy, dn;
        @(posedge clk);
        #1;
        model_step();
        rdy = '0; dn = '0;
        for (int i = 0; i < N; i++) begin
            if (rnd_mode) begin
                if (m_ph[i] == 1 && ($urandom % 2) == 0) begin
                    rdy[i] = 1'b1;
                    dn[i]  = (($urandom % 7) == 0);
                end
                if (m_ph[i] == 2) dn[i] = (($urandom % 6) == 0);
            end else begin
                if (m_ph[i] == 1 && age[i] >= rdly[i]) begin
                    rdy[i] = 1'b1;
                    dn[i]  = (ddly[i] == 0);
                end
                if (m_ph[i] == 2 && age[i] + 1 >= ddly[i]) dn[i] = 1'b1;
            end
        end
        stage_ready = rdy;
        stage_done  = dn;
        frame_req   = rnd_mode ? (($urandom % 2) == 0) : req_next;
        stall_clear = rnd_mode ? (($urandom % 50) == 0) : clr_next;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int left, busy;
        left = budget;
        busy = 1;
        while (busy != 0 && left > 0) begin
            step();
            left--;
            busy = (m_infl != 0) ? 1 : 0;
            for (int i = 0; i < N; i++) if (m_ph[i] != 0 || m_pend[i] != 0) busy = 1;
        end
        if (busy != 0) check({name, "_drain_timeout"}, 1, 0);
        repeat (3) step();
    endtask

    always @(negedge clk) begin : cmp
        int e;
        if (chk_en) begin
            e = 0;
            for (int i = 0; i < N; i++) if (m_ph[i] == 1) e |= (1 << i);
            check("frame_ack", int'(frame_ack), (frame_req && m_infl < MAXI && m_stall == 0) ? 1 : 0);
            check("stage_start", int'(stage_start), e);
            check("frame_done", int'(frame_done), m_fdone);
            check("inflight", int'(inflight), m_infl);
            check("stall", int'(stall), m_stall);
            if (m_stall != 0) check("stall_stage", int'(stall_stage), m_stall_stage);
            n_ack   += int'(frame_ack);
            n_fdone += int'(frame_done);
            for (int i = 0; i < N; i++) n_start_cyc[i] += int'(stage_start[i]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int left, tot;
        model_reset();
        clear_counts();
        for (int i = 0; i < N; i++) begin rdly[i] = 1; ddly[i] = 10; end

        repeat (3) @(posedge clk);
        #1;
        check("rst_stage_start", int'(stage_start), 0);
        check("rst_inflight", int'(inflight), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_stall_stage", int'(stall_stage), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single frame, ready 1 cycle after start, done 10 cycles after ready.
        clear_counts();
        req_next = 1'b1; step(); req_next = 1'b0;
        run_until_idle("single", 200);
        tot = 0;
        for (int i = 0; i < N; i++) tot += n_start_cyc[i];
        check("single_acks", n_ack, 1);
        check("single_start_cycles", tot, 8);
        check("single_frame_done", n_fdone, 1);
        check("single_inflight_end", int'(inflight), 0);

        // Back-to-back requests with a slow last stage.
        clear_counts();
        ddly[3] = 40;
        req_next = 1'b1;
        repeat (30) step();
        check("b2b_acks_held", n_ack, 2);
        left = 300;
        while (n_ack < 3 && left > 0) begin step(); left--; end
        if (n_ack < 3) check("b2b_third_ack_timeout", n_ack, 3);
        check("b2b_fdone_at_third_ack", n_fdone, 1);
        req_next = 1'b0;
        run_until_idle("b2b", 400);
        check("b2b_frame_done", n_fdone, 3);
        ddly[3] = 10;

        // Stage 2 returns ready and done together.
        clear_counts();
        ddly[2] = 0;
        req_next = 1'b1; step(); req_next = 1'b0;
        run_until_idle("samecyc", 200);
        check("samecyc_start2_cycles", n_start_cyc[2], 2);
        check("samecyc_start3_cycles", n_start_cyc[3], 2);
        check("samecyc_frame_done", n_fdone, 1);
        ddly[2] = 10;

        // Randomized traffic.
        rnd_mode = 1'b1;
        repeat (1500) step();
        rnd_mode = 1'b0;
        req_next = 1'b0;
        clr_next = 1'b1; step(); clr_next = 1'b0;
        run_until_idle("random", 600);

        // Watchdog: stage 1 never finishes.
        ddly[1] = 100000;
        req_next = 1'b1; step(); req_next = 1'b0;
        left = 400;
        while (stall !== 1'b1 && left > 0) begin step(); left--; end
        check("wd_stall_set", int'(stall), 1);
        check("wd_stall_stage", int'(stall_stage), 1);
        req_next = 1'b1; step();
        check("wd_no_ack", int'(frame_ack), 0);
        req_next = 1'b0;
        clr_next = 1'b1; step(); clr_next = 1'b0;
        step();
        check("wd_stall_cleared", int'(stall), 0);
        ddly[1] = 10;
        run_until_idle("wd", 300);

        // Reset while stage 2 is busy with two frames in flight.
        ddly[2] = 100000;
        req_next = 1'b1; step(); step(); req_next = 1'b0;
        left = 200;
        while (!(m_ph[2] == 2 && m_infl == 2) && left > 0) begin step(); left--; end
        if (left == 0) check("rst_mid_setup_timeout", 0, 1);
        check("rst_mid_pre_inflight", int'(inflight), 2);
        @(posedge clk);
        chk_en = 1'b0;
        #2;
        stage_ready = '0; stage_done = '0; frame_req = 1'b0; stall_clear = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_stage_start", int'(stage_start), 0);
        check("rst_mid_inflight", int'(inflight), 0);
        check("rst_mid_frame_done", int'(frame_done), 0);
        check("rst_mid_stall", int'(stall), 0);
        check("rst_mid_frame_ack", int'(frame_ack), 0);
        model_reset();
        ddly[2] = 10;
        repeat (2) @(posedge clk);
        #1;
        clear_counts();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (40) step();
        tot = 0;
        for (int i = 0; i < N; i++) tot += n_start_cyc[i];
        check("post_rst_no_start", tot, 0);
        check("post_rst_no_frame_done", n_fdone, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_hog_pipe_sequencer
`default_nettype wire

// File: doc/hog_pipe_sequencer.md
HOG_PIPE_SEQUENCER -- requirements
Module: hog_pipe_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of chained dataflow stages (acquire, gradients, cells, svm).
REQ-002 Parameter MAX_INFLIGHT, default 2: frames admitted but not yet completed by the last stage.
REQ-003 Parameter WD_TIMEOUT, default 65535: cycles without any stage_done before a stall is flagged; 16-bit counter.
REQ-004 clock  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 frame_req  in  1  host requests a new frame.
REQ-007 frame_ack  out  1  frame accepted this cycle.
REQ-008 stage_start  out  NUM_STAGES  ap_start per stage.
REQ-009 stage_ready  in  NUM_STAGES  ap_ready per stage.
REQ-010 stage_done  in  NUM_STAGES  ap_done per stage, one-cycle pulse.
REQ-011 frame_done  out  1  pulse per frame completed by the last stage.
REQ-012 inflight  out  2  current frame count.
REQ-013 stall  out  1  sticky watchdog flag.
REQ-014 stall_stage  out  2  stage index captured at stall.
REQ-015 stall_clear  in  1  clears stall and the watchdog counter.

Function
REQ-016 frame_ack SHALL be combinational: frame_req & (inflight < MAX_INFLIGHT) & ~stall.
REQ-017 Per-stage pending counter pend[i], 2 bits, SHALL count +1 on accept (i=0) or stage_done[i-1] (i>0) and -1 on start handshake (stage_start[i] & stage_ready[i]); simultaneous +1/-1 SHALL hold the value.
REQ-018 Per-stage FSM SHALL have states IDLE, START, BUSY.
REQ-019 IDLE -> START when pend[i] > 0; stage_start[i] SHALL be 1 only in START.
REQ-020 START SHALL hold stage_start[i] until stage_ready[i]; on ready -> BUSY, or -> IDLE if stage_done[i] arrives in the same cycle.
REQ-021 BUSY -> IDLE on stage_done[i]; stage_done[i] outside START/BUSY SHALL be ignored for FSM state but still SHALL increment pend[i+1].
REQ-022 A stage SHALL restart from IDLE no earlier than the cycle after it returns to IDLE (one cycle minimum gap).
REQ-023 inflight SHALL +1 on accept and -1 on stage_done[NUM_STAGES-1]; simultaneous events SHALL hold; it SHALL never exceed MAX_INFLIGHT or go below 0.
REQ-024 frame_done SHALL be stage_done[NUM_STAGES-1] registered, one-cycle latency.
REQ-025 Watchdog counter SHALL clear on any stage_done bit, when inflight == 0, or on stall_clear; otherwise it SHALL increment, saturating at WD_TIMEOUT.
REQ-026 stall SHALL set the cycle the counter reaches WD_TIMEOUT; stall_stage SHALL capture the lowest-index stage in START or BUSY at that cycle, else 0.
REQ-027 stall SHALL block new frame accepts only; stages in progress SHALL continue; stall_clear SHALL take priority over setting.

Reset
REQ-028 On reset low, all FSMs SHALL go to IDLE, and pend, inflight, watchdog, stall, stall_stage, frame_done and stage_start SHALL go to 0, asynchronously.
REQ-029 Reset asserted mid-frame SHALL discard all pending and in-flight frames; no frame_done SHALL follow reset release.

Structure
REQ-030 Stage FSM state encoding, NUM_STAGES, and the stage index constants SHALL live in the shared hog package.
REQ-031 One sub-module, hog_stage_ctrl (per-stage FSM plus pend counter), SHALL be instantiated NUM_STAGES times by a generate loop.

Verification
REQ-032 Single frame, each stage with ready 1 cycle after start and done 10 cycles later -> four sequential start pulses, frame_done 1 cycle after stage_done[3], inflight 1->0.
REQ-033 Three back-to-back frame_req with the last stage slow -> first two acked, third held with ack=0 until the first stage_done[3], inflight never exceeds 2.
REQ-034 ready and done asserted in the same cycle on stage 2 -> FSM START->IDLE, pend[3] increments by 1, no extra start.
REQ-035 WD_TIMEOUT=100, stage 1 never asserts done -> stall=1 at watchdog count 100, stall_stage=1, frame_req not acked; stall_clear -> stall=0.
REQ-036 Reset asserted while stage 2 is BUSY with inflight=2 -> all outputs 0 immediately; after release and no frame_req, no stage_start and no frame_done.
